// File: rtl/seq_alu_p.sv
// seq_alu_p: multi-cycle signed ALU with add, subtract, Booth multiply
// and restoring divide. A three-state FSM (IDLE, CALC, DONE) runs each
// operation. Results and flags are registered and held while done is high.
module seq_alu_p #(
    parameter int N = 16,
    parameter int M = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op_select,
    input  logic [N-1:0]     op1,
    input  logic [M-1:0]     op2,
    output logic [N+M-1:0]   res,
    output logic [N-1:0]     quo,
    output logic [M-1:0]     rem,
    output logic             ovf,
    output logic             dz,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(N + 2);

    localparam logic [N-1:0] ONE_N  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [M-1:0] ONE_M  = {{(M-1){1'b0}}, 1'b1};
    localparam logic [M:0]   ONE_M1 = {{M{1'b0}}, 1'b1};

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic [N-1:0]   a_q, a_d;
    logic [M-1:0]   b_q, b_d;

    // Booth multiplier: accumulator carries one guard bit, multiplier and Q(-1) shift below it
    logic [N:0]     acc_q, acc_d;
    logic [M-1:0]   mr_q, mr_d;
    logic           qm1_q, qm1_d;

    // Restoring divider: dividend magnitude shifts out of dq as quotient bits shift in
    logic [N-1:0]   dq_q, dq_d;
    logic [M:0]     rq_q, rq_d;
    logic [M-1:0]   dvs_q, dvs_d;
    logic           dovf_q, dovf_d;

    logic [N+M-1:0] res_q, res_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [M-1:0]   rem_q, rem_d;
    logic           ovf_q, ovf_d;
    logic           dz_q, dz_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [CW-1:0]  last_cnt;
    logic [N:0]     a_ext;
    logic [N:0]     b_ext;
    logic [N:0]     sum;
    logic [N:0]     acc_sum;
    logic [M:0]     rshift;
    logic [M:0]     dvs_ext;
    logic           q_neg;

    // Final counter value for the latched operation; divide by zero finishes in one cycle
    always_comb begin
        last_cnt = '0;
        case (op_q)
            OP_MUL:  last_cnt = CW'(M);
            OP_ADD,
            OP_SUB:  last_cnt = '0;
            default: last_cnt = (b_q == '0) ? '0 : CW'(N + 1);
        endcase
    end

    // Datapath helpers: exact N+1-bit add/sub, Booth partial sum, restoring trial shift
    always_comb begin
        a_ext   = {a_q[N-1], a_q};
        b_ext   = {{(N+1-M){b_q[M-1]}}, b_q};
        sum     = (op_q == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
        case ({mr_q[0], qm1_q})
            2'b01:   acc_sum = acc_q + a_ext;
            2'b10:   acc_sum = acc_q - a_ext;
            default: acc_sum = acc_q;
        endcase
        rshift  = {rq_q[M-1:0], dq_q[N-1]};
        dvs_ext = {1'b0, dvs_q};
        q_neg   = a_q[N-1] ^ b_q[M-1];
    end

    // Next-state and next-register logic for the IDLE/CALC/DONE controller
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        mr_d    = mr_q;
        qm1_d   = qm1_q;
        dq_d    = dq_q;
        rq_d    = rq_q;
        dvs_d   = dvs_q;
        dovf_d  = dovf_q;
        res_d   = res_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dz_d    = dz_q;
        busy_d  = busy_q;
        done_d  = done_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    op_d    = op_select;
                    a_d     = op1;
                    b_d     = op2;
                    acc_d   = '0;
                    mr_d    = op2;
                    qm1_d   = 1'b0;
                    dq_d    = op1[N-1] ? (~op1 + ONE_N) : op1;
                    rq_d    = '0;
                    dvs_d   = op2[M-1] ? (~op2 + ONE_M) : op2;
                    dovf_d  = 1'b0;
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            CALC: begin
                if (cnt_q == last_cnt) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    case (op_q)
                        OP_ADD, OP_SUB: begin
                            res_d = {{(M-1){sum[N]}}, sum};
                            quo_d = '0;
                            rem_d = '0;
                            ovf_d = sum[N] ^ sum[N-1];
                            dz_d  = 1'b0;
                        end
                        OP_MUL: begin
                            res_d = {acc_q[N-1:0], mr_q};
                            quo_d = '0;
                            rem_d = '0;
                            ovf_d = 1'b0;
                            dz_d  = 1'b0;
                        end
                        default: begin
                            res_d = '0;
                            if (b_q == '0) begin
                                quo_d = '1;
                                rem_d = '0;
                                ovf_d = 1'b0;
                                dz_d  = 1'b1;
                            end else begin
                                quo_d = dq_q;
                                rem_d = rq_q[M-1:0];
                                ovf_d = dovf_q;
                                dz_d  = 1'b0;
                            end
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (op_q == OP_MUL) begin
                        {acc_d, mr_d, qm1_d} = {acc_sum[N], acc_sum, mr_q};
                    end else if (cnt_q < CW'(N)) begin
                        if (rshift >= dvs_ext) begin
                            rq_d = rshift - dvs_ext;
                            dq_d = {dq_q[N-2:0], 1'b1};
                        end else begin
                            rq_d = rshift;
                            dq_d = {dq_q[N-2:0], 1'b0};
                        end
                    end else begin
                        dq_d   = q_neg ? (~dq_q + ONE_N) : dq_q;
                        rq_d   = a_q[N-1] ? (~rq_q + ONE_M1) : rq_q;
                        dovf_d = ~q_neg & dq_q[N-1];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any partial result immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            mr_q    <= '0;
            qm1_q   <= 1'b0;
            dq_q    <= '0;
            rq_q    <= '0;
            dvs_q   <= '0;
            dovf_q  <= 1'b0;
            res_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            mr_q    <= mr_d;
            qm1_q   <= qm1_d;
            dq_q    <= dq_d;
            rq_q    <= rq_d;
            dvs_q   <= dvs_d;
            dovf_q  <= dovf_d;
            res_q   <= res_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign res  = res_q;
    assign quo  = quo_q;
    assign rem  = rem_q;
    assign ovf  = ovf_q;
    assign dz   = dz_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_alu_p.sv
// Testbench for seq_alu_p: scoreboard of expected results from a small
// integer model, one task per feature, all comparisons inline.
module tb_seq_alu_p;

    localparam int N = 16;
    localparam int M = 8;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [1:0]     op_select = 2'b00;
    logic [N-1:0]   op1 = '0;
    logic [M-1:0]   op2 = '0;
    logic [N+M-1:0] res;
    logic [N-1:0]   quo;
    logic [M-1:0]   rem;
    logic           ovf;
    logic           dz;
    logic           busy;
    logic           done;

    seq_alu_p #(.N(N), .M(M)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op_select (op_select),
        .op1       (op1),
        .op2       (op2),
        .res       (res),
        .quo       (quo),
        .rem       (rem),
        .ovf       (ovf),
        .dz        (dz),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N+M-1:0] res;
        logic [N-1:0]   quo;
        logic [M-1:0]   rem;
        logic           ovf;
        logic           dz;
        int             lat;
    } exp_t;

    exp_t sb[$];
    int n_assert = 0;
    int n_fail   = 0;

    // Reference model on wide integers: truncating divide, exact sums and products
    function automatic exp_t model(input logic [1:0] op, input longint a, input longint b);
        exp_t   m;
        longint r, q, rr, lo, hi;
        lo = -(longint'(1) << (N-1));
        hi = (longint'(1) << (N-1)) - 1;
        m.res = '0; m.quo = '0; m.rem = '0; m.ovf = 1'b0; m.dz = 1'b0; m.lat = 1;
        case (op)
            2'd0, 2'd1: begin
                r = (op == 2'd0) ? (a + b) : (a - b);
                m.res = r[N+M-1:0];
                m.ovf = (r > hi) || (r < lo);
            end
            2'd2: begin
                r = a * b;
                m.res = r[N+M-1:0];
                m.lat = M + 1;
            end
            default: begin
                if (b == 0) begin
                    m.dz  = 1'b1;
                    m.quo = '1;
                end else begin
                    m.lat = N + 2;
                    if (a == lo && b == -1) begin
                        m.quo = lo[N-1:0];
                        m.ovf = 1'b1;
                    end else begin
                        q  = a / b;
                        rr = a % b;
                        m.quo = q[N-1:0];
                        m.rem = rr[M-1:0];
                    end
                end
            end
        endcase
        return m;
    endfunction

    // Drive one request so that it is sampled at the next rising edge (edge 0)
    task automatic applyStimulus(input logic [1:0] op, input longint a, input longint b);
        @(negedge clk);
        op_select = op;
        op1 = a[N-1:0];
        op2 = b[M-1:0];
        start = 1'b1;
        sb.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Advance edges until done is seen or the budget runs out
    task automatic wait_done(inout int edges);
        while (done !== 1'b1 && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        n_assert++;
        if ({res, quo, rem, ovf, dz, busy, done} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got res=%h quo=%h rem=%h flags=%b, want all zero",
                     res, quo, rem, {ovf, dz, busy, done});
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_assert++;
        if ({res, quo, rem, ovf, dz, busy, done} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_idle: got res=%h flags=%b, want all zero", res, {ovf, dz, busy, done});
        end
    endtask

    task automatic test_add_sub();
        logic [1:0] op_tab[5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
        longint     a_tab[5]  = '{10, 32767, -8, 7, -32768};
        longint     b_tab[5]  = '{5, 1, 3, -2, 1};
        exp_t       e;
        int         edges;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(op_tab[i], a_tab[i], b_tab[i]);
            n_assert++;
            if ({busy, done} !== 2'b10) begin
                n_fail++;
                $display("[TB] FAIL addsub%0d_edge0: got busy/done=%b, want 10", i, {busy, done});
            end
            edges = 0;
            wait_done(edges);
            e = sb.pop_front();
            n_assert++;
            if (edges !== e.lat) begin
                n_fail++;
                $display("[TB] FAIL addsub%0d_latency: got %0d, want %0d", i, edges, e.lat);
            end
            n_assert++;
            if (res !== e.res) begin
                n_fail++;
                $display("[TB] FAIL addsub%0d_res: got %0d, want %0d", i, $signed(res), $signed(e.res));
            end
            n_assert++;
            if ({quo, rem} !== {e.quo, e.rem}) begin
                n_fail++;
                $display("[TB] FAIL addsub%0d_quo_rem: got %h/%h, want %h/%h", i, quo, rem, e.quo, e.rem);
            end
            n_assert++;
            if ({ovf, dz, busy} !== {e.ovf, e.dz, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL addsub%0d_flags: got ovf/dz/busy=%b, want %b", i, {ovf, dz, busy}, {e.ovf, e.dz, 1'b0});
            end
        end
    endtask

    task automatic test_mul();
        longint a_tab[4] = '{-7, -32768, 32767, 123};
        longint b_tab[4] = '{-2, -128, 127, -128};
        exp_t   e;
        int     edges;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'd2, a_tab[i], b_tab[i]);
            edges = 0;
            wait_done(edges);
            e = sb.pop_front();
            n_assert++;
            if (edges !== e.lat) begin
                n_fail++;
                $display("[TB] FAIL mul%0d_latency: got %0d, want %0d", i, edges, e.lat);
            end
            n_assert++;
            if (res !== e.res) begin
                n_fail++;
                $display("[TB] FAIL mul%0d_res: got %0d, want %0d", i, $signed(res), $signed(e.res));
            end
            n_assert++;
            if ({quo, rem, ovf, dz, busy} !== {e.quo, e.rem, e.ovf, e.dz, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL mul%0d_side: got quo=%h rem=%h ovf/dz/busy=%b, want zeros",
                         i, quo, rem, {ovf, dz, busy});
            end
        end
    endtask

    task automatic test_div();
        longint a_tab[5] = '{1234, 4112, -1234, 1234, -32768};
        longint b_tab[5] = '{33, 40, 33, -33, 1};
        exp_t   e;
        int     edges;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'd3, a_tab[i], b_tab[i]);
            edges = 0;
            wait_done(edges);
            e = sb.pop_front();
            n_assert++;
            if (edges !== e.lat) begin
                n_fail++;
                $display("[TB] FAIL div%0d_latency: got %0d, want %0d", i, edges, e.lat);
            end
            n_assert++;
            if (quo !== e.quo) begin
                n_fail++;
                $display("[TB] FAIL div%0d_quo: got %0d, want %0d", i, $signed(quo), $signed(e.quo));
            end
            n_assert++;
            if (rem !== e.rem) begin
                n_fail++;
                $display("[TB] FAIL div%0d_rem: got %0d, want %0d", i, $signed(rem), $signed(e.rem));
            end
            n_assert++;
            if ({res, ovf, dz, busy} !== {e.res, e.ovf, e.dz, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL div%0d_side: got res=%h ovf/dz/busy=%b, want %h %b",
                         i, res, {ovf, dz, busy}, e.res, {e.ovf, e.dz, 1'b0});
            end
        end
    endtask

    task automatic test_div_corners();
        longint a_tab[2] = '{100, -32768};
        longint b_tab[2] = '{0, -1};
        exp_t   e;
        int     edges;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(2'd3, a_tab[i], b_tab[i]);
            if (i == 1) begin
                n_assert++;
                if ({ovf, dz} !== 2'b00) begin
                    n_fail++;
                    $display("[TB] FAIL corner_flag_clear: got ovf/dz=%b at edge 0, want 00", {ovf, dz});
                end
            end
            edges = 0;
            wait_done(edges);
            e = sb.pop_front();
            n_assert++;
            if (edges !== e.lat) begin
                n_fail++;
                $display("[TB] FAIL corner%0d_latency: got %0d, want %0d", i, edges, e.lat);
            end
            n_assert++;
            if ({quo, rem} !== {e.quo, e.rem}) begin
                n_fail++;
                $display("[TB] FAIL corner%0d_quo_rem: got %0d/%0d, want %0d/%0d",
                         i, $signed(quo), $signed(rem), $signed(e.quo), $signed(e.rem));
            end
            n_assert++;
            if ({res, ovf, dz} !== {e.res, e.ovf, e.dz}) begin
                n_fail++;
                $display("[TB] FAIL corner%0d_flags: got res=%h ovf/dz=%b, want %h %b",
                         i, res, {ovf, dz}, e.res, {e.ovf, e.dz});
            end
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        int   edges;
        applyStimulus(2'd3, 1234, 33);
        edges = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            edges++;
        end
        @(negedge clk);
        op_select = 2'd0;
        op1 = 16'd1;
        op2 = 8'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        edges++;
        start = 1'b0;
        wait_done(edges);
        e = sb.pop_front();
        n_assert++;
        if (edges !== e.lat) begin
            n_fail++;
            $display("[TB] FAIL ignore_latency: got %0d, want %0d", edges, e.lat);
        end
        n_assert++;
        if ({res, quo, rem} !== {e.res, e.quo, e.rem}) begin
            n_fail++;
            $display("[TB] FAIL ignore_result: got res=%h quo=%0d rem=%0d, want res=%h quo=%0d rem=%0d",
                     res, $signed(quo), $signed(rem), e.res, $signed(e.quo), $signed(e.rem));
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   edges;
        applyStimulus(2'd0, 10, 5);
        edges = 0;
        wait_done(edges);
        e = sb.pop_front();
        n_assert++;
        if ({edges, res} !== {e.lat, e.res}) begin
            n_fail++;
            $display("[TB] FAIL b2b_first: got %0d edges res=%0d, want %0d edges res=%0d",
                     edges, $signed(res), e.lat, $signed(e.res));
        end
        op_select = 2'd1;
        op1 = 16'd7;
        op2 = 8'hFE;
        start = 1'b1;
        sb.push_back(model(2'd1, 7, -2));
        @(posedge clk);
        #1;
        start = 1'b0;
        n_assert++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL b2b_done_drop: got busy/done=%b, want 10", {busy, done});
        end
        edges = 0;
        wait_done(edges);
        e = sb.pop_front();
        n_assert++;
        if ({edges, res, ovf} !== {e.lat, e.res, e.ovf}) begin
            n_fail++;
            $display("[TB] FAIL b2b_second: got %0d edges res=%0d ovf=%b, want %0d edges res=%0d ovf=%b",
                     edges, $signed(res), ovf, e.lat, $signed(e.res), e.ovf);
        end
    endtask

    task automatic test_reset_mid_op();
        exp_t e;
        int   edges;
        applyStimulus(2'd3, -1234, 33);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_assert++;
        if ({res, quo, rem, ovf, dz, busy, done} !== '0) begin
            n_fail++;
            $display("[TB] FAIL midreset_outputs: got res=%h quo=%h rem=%h flags=%b, want all zero",
                     res, quo, rem, {ovf, dz, busy, done});
        end
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_assert++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL midreset_idle: got busy/done=%b, want 00", {busy, done});
        end
        applyStimulus(2'd2, 6, 3);
        edges = 0;
        wait_done(edges);
        e = sb.pop_front();
        n_assert++;
        if ({edges, res} !== {e.lat, e.res}) begin
            n_fail++;
            $display("[TB] FAIL midreset_mul: got %0d edges res=%0d, want %0d edges res=%0d",
                     edges, $signed(res), e.lat, $signed(e.res));
        end
    endtask

    task automatic test_random();
        logic [N-1:0] ra;
        logic [M-1:0] rb;
        logic [1:0]   op;
        exp_t         e;
        int           edges;
        for (int i = 0; i < 12; i++) begin
            ra = N'($urandom);
            rb = M'($urandom);
            op = 2'($urandom_range(0, 3));
            applyStimulus(op, longint'($signed(ra)), longint'($signed(rb)));
            edges = 0;
            wait_done(edges);
            e = sb.pop_front();
            n_assert++;
            if ({edges, res, quo, rem, ovf, dz} !== {e.lat, e.res, e.quo, e.rem, e.ovf, e.dz}) begin
                n_fail++;
                $display("[TB] FAIL rand%0d op=%0d a=%0d b=%0d: got %0d/%h/%h/%h/%b%b, want %0d/%h/%h/%h/%b%b",
                         i, op, $signed(ra), $signed(rb), edges, res, quo, rem, ovf, dz,
                         e.lat, e.res, e.quo, e.rem, e.ovf, e.dz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_div_corners();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
